// File: rtl/spi_command_rx_pkg.sv
// Shared constants and the MISO status-byte packer for the SPI command receiver.
package spi_command_rx_pkg;
  localparam int SPI_RX_BYTE_WIDTH  = 8;
  localparam int SPI_RX_FIFO_DEPTH  = 16;
  localparam int ST_OVF_BIT         = 7;
  localparam int ST_FULL_BIT        = 6;
  localparam int ST_LVL_MSB         = 5;

  // Status byte layout: {overflow, full, level saturated to 6 bits}.
  function automatic logic [SPI_RX_BYTE_WIDTH-1:0] status_byte(
    input logic ovf, input logic full, input int unsigned lvl);
    logic [ST_LVL_MSB:0] l;
    l = (lvl > 63) ? 6'd63 : 6'(lvl);
    return {ovf, full, l};
  endfunction
endpackage

// File: rtl/spi_command_rx_if.sv
// Controller-side byte stream: FWFT head, pop strobe, occupancy and overflow status.
interface spi_command_rx_if
  import spi_command_rx_pkg::*;
  #(parameter int LVL_W = 5);
  logic [SPI_RX_BYTE_WIDTH-1:0] in_byte;
  logic                         in_ready;
  logic                         next;
  logic [LVL_W-1:0]             fifo_level;
  logic                         overflow;
  logic                         clear_overflow;

  modport master (output next, clear_overflow,
                  input  in_byte, in_ready, fifo_level, overflow);
  modport slave  (input  next, clear_overflow,
                  output in_byte, in_ready, fifo_level, overflow);
endinterface

// File: rtl/spi_command_rx_byte_fifo_fwft.sv
// First-word-fall-through byte FIFO; pointers carry an extra wrap bit for full/empty.
module byte_fifo_fwft
  import spi_command_rx_pkg::*;
  #(parameter int DEPTH = SPI_RX_FIFO_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int PW = AW + 1)
  (input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [SPI_RX_BYTE_WIDTH-1:0] i_din,
   output logic [SPI_RX_BYTE_WIDTH-1:0] o_dout,
   output logic [PW-1:0]                o_level,
   output logic                         o_full,
   output logic                         o_empty);

  logic [SPI_RX_BYTE_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd, r_level;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt;
  logic          w_do_push, w_do_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_wr_nxt  = r_wr + PW'(w_do_push);
  assign w_rd_nxt  = r_rd + PW'(w_do_pop);
  assign o_dout    = r_mem[r_rd[AW-1:0]];
  assign o_level   = r_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
      r_wr    <= w_wr_nxt;
      r_rd    <= w_rd_nxt;
      r_level <= w_wr_nxt - w_rd_nxt;
    end
  end
endmodule

// File: rtl/spi_command_rx.sv
// SPI mode-0 byte receiver feeding a FWFT FIFO for the command controller.
// Define SPI_RX_MISO_STATUS_EN to shift a status byte out on spi_miso.
module spi_command_rx
  import spi_command_rx_pkg::*;
  #(parameter int FIFO_DEPTH  = SPI_RX_FIFO_DEPTH,
    parameter int SYNC_STAGES = 2)
  (input  logic clk,
   input  logic reset,
   input  logic spi_sck,
   input  logic spi_mosi,
   input  logic spi_cs_n,
   output logic spi_miso,
   spi_command_rx_if.slave ctl);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0]       r_sck_sync, r_mosi_sync, r_cs_sync;
  logic                         r_sck_d, r_cs_d;
  logic                         w_sck, w_mosi, w_cs_n, w_sck_rise;
  logic [2:0]                   r_bit_cnt;
  logic [6:0]                   r_shift;
  logic [SPI_RX_BYTE_WIDTH-1:0] w_byte_nxt, r_push_byte;
  logic                         r_push, r_overflow;
  logic                         w_full, w_empty, w_drop;
  logic [LW-1:0]                w_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_sck_d     <= w_sck;
      r_cs_d      <= w_cs_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_byte_nxt = {r_shift, w_mosi};

  // Deasserting cs_n clears the partial byte, so an aborted byte is never pushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_push_byte <= '0;
    end else begin
      r_push <= 1'b0;
      if (w_cs_n) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (w_sck_rise) begin
        r_shift   <= w_byte_nxt[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_push      <= 1'b1;
          r_push_byte <= w_byte_nxt;
        end
      end
    end
  end

  byte_fifo_fwft #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (r_push),
    .i_pop   (ctl.next),
    .i_din   (r_push_byte),
    .o_dout  (ctl.in_byte),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty));

  assign w_drop = r_push & w_full & ~(ctl.next & ~w_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_overflow <= 1'b0;
    else if (w_drop)             r_overflow <= 1'b1;
    else if (ctl.clear_overflow) r_overflow <= 1'b0;
  end

  assign ctl.in_ready   = ~w_empty;
  assign ctl.fifo_level = w_level;
  assign ctl.overflow   = r_overflow;

`ifdef SPI_RX_MISO_STATUS_EN
  logic [SPI_RX_BYTE_WIDTH-1:0] r_tx, w_status;
  logic                         w_sck_fall, w_cs_fall;

  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_fall  = ~w_cs_n & r_cs_d;
  assign w_status   = status_byte(r_overflow, w_full, int'(w_level));

  // Counter back at 0 on a falling edge means a byte boundary just passed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_tx <= '0;
    else if (w_cs_n)     r_tx <= '0;
    else if (w_cs_fall)  r_tx <= w_status;
    else if (w_sck_fall) r_tx <= (r_bit_cnt == 3'd0) ? w_status : {r_tx[6:0], 1'b0};
  end

  assign spi_miso = r_tx[SPI_RX_BYTE_WIDTH-1];
`else
  assign spi_miso = 1'b0;
`endif
endmodule

// File: doc/spi_command_rx.md
Name: spi_command_rx

Overview:
Upstream byte source for the command controller. It receives SPI mode-0 bytes from the host MCU, synchronises them into the clk domain and buffers them in a first-word-fall-through (FWFT) byte FIFO. It presents the FIFO head as in_byte/in_ready and pops one byte per next pulse from the controller.

Parameters:
fifo_depth, 16, FIFO entries; power of two, >= 2
sync_stages, 2, synchroniser flops on sck/mosi/cs_n; >= 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
spi_sck  input  1  SPI clock, asynchronous to clk
spi_mosi  input  1  SPI data in, MSB first
spi_cs_n  input  1  SPI chip select, active low
spi_miso  output  1  SPI data out (see Optional Feature)
in_byte  output  8  FIFO head byte
in_ready  output  1  high while FIFO is non-empty
next  input  1  one-cycle pop strobe from controller
fifo_level  output  $clog2(fifo_depth)+1  current occupancy
overflow  output  1  sticky: a byte was dropped because the FIFO was full
clear_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): FIFO empty, in_ready=0, in_byte=0, fifo_level=0, overflow=0, spi_miso=0, bit counter=0, shift register=0, synchroniser flops set to idle (sck=0, cs_n=1).
- Front end: sck, mosi and cs_n each pass through sync_stages flops; one more flop gives edge detection. SPI clock spec: sck <= clk/8.
- Receive:
  - On a synchronised sck rise with cs_n low, shift mosi into the LSB and increment the 3-bit counter.
  - On the 8th bit, the assembled byte generates a push strobe in the next clk cycle, and the counter wraps to 0.
- cs_n high: bit counter and shift register are held at 0.
- cs_n rising mid-byte: the partial byte is discarded and nothing is pushed.
- FIFO:
  - Circular buffer with wr_ptr/rd_ptr, each $clog2(fifo_depth)+1 bits; the MSB distinguishes full from empty.
  - in_byte = mem[rd_ptr], FWFT.
  - in_ready = (level != 0).
- Pop: next high while in_ready=1 advances rd_ptr at that edge; the new head and in_ready are valid the following cycle. Under the controller protocol, next fires one cycle after the sample and the controller skips one cycle before the next sample, so no stale byte is read twice.
- Pop when empty: ignored, with no pointer change.
- Push when not full: write the byte and advance wr_ptr.
- Push when full, no simultaneous pop: drop the byte and set overflow.
- Push and pop in the same cycle:
  - FIFO full: both take effect, level unchanged, no overflow.
  - FIFO empty: byte is written; in_ready rises the next cycle; the pop is ignored.
- clear_overflow clears overflow. If clear_overflow and a new drop occur in the same cycle, set wins.
- fifo_level = wr_ptr - rd_ptr, registered, updated with the pointers.
- No combinational path from next to in_byte or in_ready.

Optional Feature:
- Macro SPI_RX_MISO_STATUS_EN.
- When defined:
  - On cs_n falling, capture status byte {overflow, full, level[5:0] saturated at 63} into a tx shift register.
  - spi_miso presents the MSB and shifts on each synchronised sck fall.
  - The status byte reloads at every byte boundary.
  - spi_miso=0 while cs_n is high.
- When undefined: spi_miso is tied 0 and no tx logic is synthesised.

Decomposition:
- Shared package/header (spi_rx.vh): SPI_RX_BYTE_WIDTH=8, status-byte bit positions, default fifo_depth.
- One sub-module, byte_fifo_fwft: parameterised depth, push/pop/din/dout/level/full/empty.
- sync/edge logic and the shift register stay in the top module.

Test Plan:
- Send 0xA5 with cs_n low, sck = clk/8 -> in_ready rises within sync_stages+3 clk after the 8th sck rise; in_byte=0xA5, level=1; next pulse -> in_ready=0 the next cycle.
- Send 0x01, 0x03, 0xAB, 0xCD, then pop via a controller-like model (next one cycle after sample, skip one) -> bytes read in order, no duplicates; level counts 4→0.
- Send 20 bytes with no pops (depth 16) -> level=16, overflow=1, the first 16 are retained in order; clear_overflow -> overflow=0.
- FIFO full, push and next in the same cycle -> level stays 16, overflow stays 0, head advances.
- Send 5 bits then raise cs_n, then send a full 0x3C -> only 0x3C is pushed, level=1.
- Assert reset mid-byte with 3 bytes queued -> outputs immediately 0; after release, a fresh byte 0x7E is received correctly. With SPI_RX_MISO_STATUS_EN defined and overflow=1, level=2 -> miso shifts 0x82.
